// File: rtl/fifo_arb_pkg.sv
// Shared types, default widths and the round-robin search helper for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam int unsigned NUM_REQ_DFLT   = 4;
    localparam int unsigned MAX_BURST_DFLT = 4;
    localparam int unsigned OWNER_W        = $clog2(NUM_REQ_DFLT);
    localparam int unsigned CNT_W          = $clog2(MAX_BURST_DFLT + 1);

    // Widest request vector the helper accepts.
    localparam int unsigned MAX_REQ   = 32;
    localparam int unsigned MAX_REQ_W = 5;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    // First set bit at or above ptr, wrapping at n; returns ptr when nothing is set.
    function automatic int unsigned next_rr(input logic [MAX_REQ-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned sel;
        int unsigned j;
        logic        found;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            j = ptr + i;
            if (j >= n) begin
                j = j - n;
            end
            if (!found && req[MAX_REQ_W'(j)]) begin
                sel   = j;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side handshake bundle of the write-port arbiter.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OWNER_W    = fifo_arb_pkg::OWNER_W
);

    logic [NUM_REQ-1:0]            Req;
    logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data;
    logic [NUM_REQ-1:0]            Req_Last;
    logic [NUM_REQ-1:0]            Grant;
    logic [NUM_REQ-1:0]            Req_Ack;
    logic [OWNER_W-1:0]            Owner;
    logic                          Busy;
    logic                          FIFO_Wr_Req;
    logic [DATA_WIDTH-1:0]         FIFO_D_IN;
    logic                          FIFO_Full;
    logic                          FIFO_Wr_Ack;
    logic                          Ack_Err;

    modport master (
        input  Req, Req_Data, Req_Last, FIFO_Full, FIFO_Wr_Ack,
        output Grant, Req_Ack, Owner, Busy, FIFO_Wr_Req, FIFO_D_IN, Ack_Err
    );

    modport slave (
        output Req, Req_Data, Req_Last, FIFO_Full, FIFO_Wr_Ack,
        input  Grant, Req_Ack, Owner, Busy, FIFO_Wr_Req, FIFO_D_IN, Ack_Err
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or above ptr, with wrap.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned OWNER_W = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [OWNER_W-1:0] idx,
    output logic               any
);
    import fifo_arb_pkg::*;

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        idx                  = OWNER_W'(next_rr(req_ext, 32'(ptr), NUM_REQ));
        any                  = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ write-domain producers,
// with bursts of up to MAX_BURST words and a sticky check for missing write acknowledges.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned OWNER_W    = $clog2(NUM_REQ),
    parameter int unsigned CNT_W      = $clog2(MAX_BURST + 1)
) (
    input logic               CLK,
    input logic               rst_n,
    fifo_wr_arbiter_if.master bus
);
    import fifo_arb_pkg::*;

    state_e                               state_q, state_d;
    logic   [OWNER_W-1:0]                 owner_q, owner_d;
    logic   [OWNER_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic   [NUM_REQ-1:0]                 grant_q, grant_d;
    logic                                 busy_q, busy_d;
    logic   [CNT_W-1:0]                   cnt_q, cnt_d;
    logic                                 ack_err_q, ack_err_d;
    logic                                 wr_pend_q;
    logic   [OWNER_W-1:0]                 pick_idx;
    logic                                 pick_any;
    logic   [OWNER_W-1:0]                 owner_inc;
    logic                                 xfer;
    logic                                 release_burst;
    logic   [NUM_REQ-1:0][DATA_WIDTH-1:0] req_words;

    assign req_words = bus.Req_Data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OWNER_W (OWNER_W)
    ) u_rr_pick (
        .req (bus.Req),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Explicit wrap so non-power-of-2 NUM_REQ never points past the last producer.
    assign owner_inc = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + OWNER_W'(1);

    always_comb begin
        xfer            = (state_q == StBurst) && bus.Req[owner_q] && !bus.FIFO_Full;
        bus.FIFO_Wr_Req = xfer;
        bus.Req_Ack     = '0;
        bus.FIFO_D_IN   = '0;
        if (xfer) begin
            bus.Req_Ack[owner_q] = 1'b1;
            bus.FIFO_D_IN        = req_words[owner_q];
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        busy_d        = busy_q;
        cnt_d         = cnt_q;
        release_burst = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d           = StBurst;
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    busy_d            = 1'b1;
                    cnt_d             = '0;
                end
            end
            StBurst: begin
                if (!bus.Req[owner_q]) begin
                    release_burst = 1'b1;
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bus.Req_Last[owner_q] || cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        release_burst = 1'b1;
                    end
                end
                if (release_burst) begin
                    state_d  = StIdle;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    rr_ptr_d = owner_inc;
                end
            end
            default: state_d = StIdle;
        endcase
        ack_err_d = ack_err_q | (wr_pend_q & ~bus.FIFO_Wr_Ack);
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            ack_err_q <= 1'b0;
            wr_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            ack_err_q <= ack_err_d;
            wr_pend_q <= xfer;
        end
    end

    assign bus.Grant   = grant_q;
    assign bus.Owner   = owner_q;
    assign bus.Busy    = busy_q;
    assign bus.Ack_Err = ack_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter; producers are word lists and a
// cycle-level reference model predicts every output each cycle.
module tb_fifo_wr_arbiter;
    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned MB    = 4;
    localparam int unsigned OW    = fifo_arb_pkg::OWNER_W;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .OWNER_W(OW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .OWNER_W    (OW),
        .CNT_W      (fifo_arb_pkg::CNT_W)
    ) dut (
        .CLK   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Producer word lists
    logic [DW-1:0] p_data [N][DEPTH];
    bit            p_last [N][DEPTH];
    int            p_head [N];
    int            p_len  [N];
    bit            mute   [N];
    bit            full;
    bit            drop_ack;
    bit            ack_in;

    logic [N-1:0]    cur_req, cur_last;
    logic [N*DW-1:0] cur_data;

    // Reference model
    bit m_busy, m_err, m_pend;
    int m_owner, m_cnt, m_ptr;
    int n_wr, burst_words;
    int grants_q[$];
    int bursts_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int i, input int n, input bit with_last);
        p_head[i] = 0;
        p_len[i]  = n;
        for (int k = 0; k < n; k++) begin
            p_data[i][k] = DW'($urandom);
            p_last[i][k] = with_last && (k == n - 1);
        end
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) begin
            if (!mute[i]) s += p_len[i] - p_head[i];
        end
        return s;
    endfunction

    task automatic drive();
        cur_req  = '0;
        cur_last = '0;
        cur_data = '0;
        for (int i = 0; i < N; i++) begin
            if (p_head[i] < p_len[i] && !mute[i]) begin
                cur_req[i]             = 1'b1;
                cur_last[i]            = p_last[i][p_head[i]];
                cur_data[i*DW +: DW]   = p_data[i][p_head[i]];
            end
        end
        bus.Req       = cur_req;
        bus.Req_Last  = cur_last;
        bus.Req_Data  = cur_data;
        bus.FIFO_Full = full;
    endtask

    task automatic cycle();
        bit            x;
        int            o;
        logic [N-1:0]  exp_grant, exp_ack;
        logic [DW-1:0] exp_din;
        drive();
        @(negedge clk);
        o         = m_owner;
        x         = m_busy && cur_req[o] && !full;
        exp_grant = m_busy ? (N'(1) << o) : '0;
        exp_ack   = x ? (N'(1) << o) : '0;
        exp_din   = x ? cur_data[o*DW +: DW] : '0;
        check_eq("grant",   32'(bus.Grant),       32'(exp_grant));
        check_eq("owner",   32'(bus.Owner),       32'(m_owner));
        check_eq("busy",    32'(bus.Busy),        32'(m_busy));
        check_eq("wr_req",  32'(bus.FIFO_Wr_Req), 32'(x));
        check_eq("req_ack", 32'(bus.Req_Ack),     32'(exp_ack));
        check_eq("d_in",    32'(bus.FIFO_D_IN),   32'(exp_din));
        check_eq("ack_err", 32'(bus.Ack_Err),     32'(m_err));
        @(posedge clk);
        if (!rst_n) begin
            m_busy  = 0;
            m_owner = 0;
            m_cnt   = 0;
            m_ptr   = 0;
            m_err   = 0;
            m_pend  = 0;
        end else begin
            if (m_pend && !ack_in) m_err = 1;
            m_pend = x;
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!m_busy && cur_req[j]) begin
                        m_busy      = 1;
                        m_owner     = j;
                        m_cnt       = 0;
                        burst_words = 0;
                        grants_q.push_back(j);
                    end
                end
            end else begin
                if (x) begin
                    m_cnt++;
                    burst_words++;
                end
                if (!cur_req[o] || (x && (cur_last[o] || m_cnt == MB))) begin
                    m_busy = 0;
                    m_ptr  = (o + 1) % N;
                    bursts_q.push_back(burst_words);
                end
            end
        end
        if (x) begin
            n_wr++;
            p_head[o]++;
        end
        #1;
        ack_in          = x && !drop_ack;
        bus.FIFO_Wr_Ack = ack_in;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            p_head[i] = 0;
            p_len[i]  = 0;
            mute[i]   = 0;
        end
        full     = 0;
        drop_ack = 0;
        cycle();
        cycle();
        rst_n = 1'b1;
        grants_q.delete();
        bursts_q.delete();
        n_wr = 0;
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            cycle();
            done = !m_busy && pending() == 0;
        end
        check_eq("drain_done", 32'(done), 32'd1);
    endtask

    task automatic run_until_writes(input int target, input int budget);
        for (int c = 0; c < budget && n_wr < target; c++) cycle();
        check_eq("writes_reached", 32'(n_wr >= target), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        rst_n           = 1'b0;
        full            = 0;
        drop_ack        = 0;
        ack_in          = 0;
        bus.FIFO_Wr_Ack = 1'b0;
        for (int i = 0; i < N; i++) begin
            p_head[i] = 0;
            p_len[i]  = 0;
            mute[i]   = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_grant",  32'(bus.Grant),       32'd0);
        check_eq("rst_busy",   32'(bus.Busy),        32'd0);
        check_eq("rst_owner",  32'(bus.Owner),       32'd0);
        check_eq("rst_wr_req", 32'(bus.FIFO_Wr_Req), 32'd0);
        check_eq("rst_d_in",   32'(bus.FIFO_D_IN),   32'd0);
        check_eq("rst_err",    32'(bus.Ack_Err),     32'd0);
        rst_n = 1'b1;

        // Single requester, 3-word packet
        load(1, 3, 1);
        cycle();
        check_eq("t1_grant", 32'(bus.Grant), 32'h2);
        wr0 = n_wr;
        repeat (3) cycle();
        check_eq("t1_writes", 32'(n_wr - wr0), 32'd3);
        check_eq("t1_busy", 32'(bus.Busy), 32'd0);
        load(1, 2, 1);
        load(3, 2, 1);
        grants_q.delete();
        drain(40);
        check_eq("t1_next_owner", 32'(grants_q[0]), 32'd3);
        check_eq("t1_then_owner", 32'(grants_q[1]), 32'd1);

        // Fairness with all four requesting
        reset_dut();
        for (int i = 0; i < N; i++) load(i, 8, 0);
        repeat (20) cycle();
        check_eq("t2_writes20", 32'(n_wr), 32'd16);
        repeat (2) cycle();
        for (int k = 0; k < 5; k++) check_eq("t2_owner_seq", 32'(grants_q[k]), 32'(k % N));
        for (int k = 0; k < 4; k++) check_eq("t2_burst_len", 32'(bursts_q[k]), 32'd4);
        drain(80);

        // FIFO full stall mid-burst
        reset_dut();
        load(2, 4, 0);
        run_until_writes(2, 10);
        full = 1;
        repeat (5) begin
            cycle();
            check_eq("t3_stall_wr",  32'(bus.FIFO_Wr_Req), 32'd0);
            check_eq("t3_stall_ack", 32'(bus.Req_Ack),     32'd0);
            check_eq("t3_grant",     32'(bus.Grant),       32'h4);
        end
        check_eq("t3_stall_cnt", 32'(n_wr), 32'd2);
        full = 0;
        drain(20);
        check_eq("t3_burst", 32'(bursts_q[0]), 32'd4);
        check_eq("t3_nbursts", 32'(bursts_q.size()), 32'd1);

        // Owner withdraws while another producer waits
        reset_dut();
        load(1, 4, 0);
        load(3, 2, 1);
        run_until_writes(1, 10);
        mute[1] = 1;
        cycle();
        check_eq("t4_rel_grant", 32'(bus.Grant), 32'd0);
        check_eq("t4_rel_busy",  32'(bus.Busy),  32'd0);
        cycle();
        check_eq("t4_grant3", 32'(bus.Grant), 32'h8);
        mute[1] = 0;
        drain(40);
        check_eq("t4_burst1", 32'(bursts_q[0]), 32'd1);

        // Missing write acknowledge
        reset_dut();
        load(0, 3, 1);
        run_until_writes(1, 10);
        drop_ack = 1;
        cycle();
        drop_ack = 0;
        check_eq("t5_second_wr", 32'(n_wr), 32'd2);
        check_eq("t5_err_before", 32'(bus.Ack_Err), 32'd0);
        cycle();
        check_eq("t5_err_set", 32'(bus.Ack_Err), 32'd1);
        drain(20);
        check_eq("t5_err_sticky", 32'(bus.Ack_Err), 32'd1);
        reset_dut();
        check_eq("t5_err_clr", 32'(bus.Ack_Err), 32'd0);

        // Reset during a write
        load(2, 4, 0);
        run_until_writes(1, 10);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_eq("t6_grant", 32'(bus.Grant),       32'd0);
        check_eq("t6_busy",  32'(bus.Busy),        32'd0);
        check_eq("t6_wr",    32'(bus.FIFO_Wr_Req), 32'd0);
        load(1, 2, 1);
        grants_q.delete();
        drain(40);
        check_eq("t6_first_owner", 32'(grants_q[0]), 32'd1);

        // Random traffic
        reset_dut();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (p_head[i] >= p_len[i] && $urandom_range(3) == 0)
                    load(i, 1 + int'($urandom_range(5)), bit'($urandom_range(1)));
                if ($urandom_range(15) == 0) mute[i] = !mute[i];
            end
            full     = ($urandom_range(3) == 0);
            drop_ack = ($urandom_range(31) == 0);
            rst_n    = ($urandom_range(199) != 0);
            cycle();
        end
        rst_n    = 1'b1;
        full     = 0;
        drop_ack = 0;
        for (int i = 0; i < N; i++) mute[i] = 0;
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
